// File: rtl/div_stim_gen.sv
// div_stim_gen: operand sequencer feeding the signed divider.
// Emits six directed corner vectors, then NUM_RANDOM LFSR vectors.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (sampled only in IDLE or DONE)
//   out_ready       consumer accepts the current vector
//   out_valid       a/b hold a valid vector
//   a, b            dividend / divisor bit patterns
//   busy, done      run in progress / run complete
//   vec_count       vectors transferred in the current run
module div_stim_gen #(
  parameter int          DATAWIDTH  = 32,
  parameter int          NUM_RANDOM = 1024,
  parameter logic [31:0] SEED       = 32'hACE12468
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIRECTED = 2'd1;
  localparam logic [1:0] S_RANDOM   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [31:0] TAPS = 32'h80200003;

  // vec_count value while the final vector of the run is presented
  localparam logic [15:0] LAST = 16'(NUM_RANDOM + 5);

  localparam logic [DATAWIDTH-1:0] MIN =
    {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [DATAWIDTH-1:0] P1 = DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] P2 = DATAWIDTH'(2);
  localparam logic [DATAWIDTH-1:0] P7 = DATAWIDTH'(7);
  localparam logic [DATAWIDTH-1:0] N1 = DATAWIDTH'(-1);
  localparam logic [DATAWIDTH-1:0] N2 = DATAWIDTH'(-2);
  localparam logic [DATAWIDTH-1:0] N7 = DATAWIDTH'(-7);

  function automatic logic [31:0] step(input logic [31:0] s);
    step = {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [DATAWIDTH-1:0] dir_a(
    input logic [2:0] i
  );
    case (i)
      3'd1:    dir_a = P1;
      3'd2:    dir_a = N1;
      3'd3:    dir_a = MIN;
      3'd4:    dir_a = P7;
      3'd5:    dir_a = N7;
      default: dir_a = '0;
    endcase
  endfunction

  function automatic logic [DATAWIDTH-1:0] dir_b(
    input logic [2:0] i
  );
    case (i)
      3'd3:    dir_b = N1;
      3'd4:    dir_b = N2;
      3'd5:    dir_b = P2;
      default: dir_b = '0;
    endcase
  endfunction

  logic [1:0]           state_q, state_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic                 valid_q, valid_d;
  logic [15:0]          cnt_q, cnt_d;

  logic        xfer;
  logic        last;
  logic [2:0]  idx;
  logic [31:0] s1, s2;

  // Directed index equals vec_count while in DIRECTED (< 6).
  assign idx  = cnt_q[2:0];
  assign xfer = valid_q & out_ready;
  assign last = (cnt_q == LAST);
  assign s1   = step(lfsr_q);
  assign s2   = step(s1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DIRECTED;
          lfsr_d  = SEED;
          cnt_d   = '0;
          a_d     = dir_a(3'd0);
          b_d     = dir_b(3'd0);
          valid_d = 1'b1;
        end
      end
      S_DIRECTED, S_RANDOM: begin
        if (xfer) begin
          cnt_d = cnt_q + 16'd1;
          if (last) begin
            // a/b keep the final vector for inspection
            state_d = S_DONE;
            valid_d = 1'b0;
          end else if (state_q == S_DIRECTED && idx != 3'd5) begin
            a_d = dir_a(idx + 3'd1);
            b_d = dir_b(idx + 3'd1);
          end else begin
            // two LFSR steps per random vector
            state_d = S_RANDOM;
            a_d     = s1[DATAWIDTH-1:0];
            b_d     = s2[DATAWIDTH-1:0];
            lfsr_d  = s2;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign vec_count = cnt_q;
  assign busy      = (state_q == S_DIRECTED) ||
                     (state_q == S_RANDOM);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_div_stim_gen.sv
// tb_div_stim_gen: randomized bench for div_stim_gen.
// Expected vectors come from an LFSR sequence model.
module tb_div_stim_gen;

  localparam logic [31:0] SEED0 = 32'hACE12468;
  localparam int          TOT0  = 26;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, start0, rdy0, v0, busy0, done0;
  logic [31:0] a0, b0;
  logic [15:0] vc0;
  logic        rst1, start1, rdy1, v1, busy1, done1;
  logic [31:0] a1, b1;
  logic [15:0] vc1;
  logic        rst2, start2, rdy2, v2, busy2, done2;
  logic [7:0]  a2, b2;
  logic [15:0] vc2;

  div_stim_gen #(.DATAWIDTH(32), .NUM_RANDOM(20)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .out_ready(rdy0),
    .out_valid(v0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .vec_count(vc0));

  div_stim_gen #(.DATAWIDTH(32), .NUM_RANDOM(4),
                 .SEED(32'h1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .out_ready(rdy1),
    .out_valid(v1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .vec_count(vc1));

  div_stim_gen #(.DATAWIDTH(8), .NUM_RANDOM(0)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .out_ready(rdy2),
    .out_valid(v2), .a(a2), .b(b2), .busy(busy2),
    .done(done2), .vec_count(vc2));

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Vector k of a run: six directed, then L(2j+1), L(2j+2).
  task automatic exp_vec(input int dw, input logic [31:0] seed,
                         input int k, output logic [31:0] ea,
                         output logic [31:0] eb);
    logic [31:0] m, l;
    m = (dw == 32) ? 32'hFFFF_FFFF : (32'h1 << dw) - 32'h1;
    case (k)
      0: begin ea = 32'd0; eb = 32'd0; end
      1: begin ea = 32'd1; eb = 32'd0; end
      2: begin ea = 32'hFFFF_FFFF; eb = 32'd0; end
      3: begin ea = 32'h1 << (dw - 1); eb = 32'hFFFF_FFFF; end
      4: begin ea = 32'd7; eb = 32'hFFFF_FFFE; end
      5: begin ea = 32'hFFFF_FFF9; eb = 32'd2; end
      default: begin
        l = seed;
        for (int n = 0; n < 2 * (k - 6) + 1; n++) l = lstep(l);
        ea = l;
        eb = lstep(l);
      end
    endcase
    ea = ea & m;
    eb = eb & m;
  endtask

  // Full u0 run; optional random stalls, random start noise,
  // or a reset (with ready high) when vector stop_at is shown.
  task automatic run0(input bit rnd_rdy, input bit rnd_start,
                      input int stop_at);
    int k, cyc;
    logic [31:0] ea, eb;
    start0 = 1'b1;
    rdy0   = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++;
    if (v0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 ||
        vc0 !== 16'd0) begin
      errors++;
      $display("FAIL start0: v=%b busy=%b done=%b vc=%0d want 1 1 0 0",
               v0, busy0, done0, vc0);
    end
    k = 0; cyc = 0; ea = 0; eb = 0;
    while (k < TOT0 && cyc < 1000) begin
      exp_vec(32, SEED0, k, ea, eb);
      checks++;
      if (v0 !== 1'b1 || busy0 !== 1'b1 || a0 !== ea ||
          b0 !== eb || vc0 !== 16'(k)) begin
        errors++;
        $display("FAIL vec0[%0d]: v=%b a=%h b=%h vc=%0d want 1 %h %h %0d",
                 k, v0, a0, b0, vc0, ea, eb, k);
      end
      if (k == stop_at) begin
        rst0 = 1'b1;
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        rdy0 = 1'b0;
        return;
      end
      rdy0   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start0 = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (rdy0) k++;
      cyc++;
    end
    rdy0   = 1'b0;
    start0 = 1'b0;
    checks++;
    if (k != TOT0) begin
      errors++;
      $display("FAIL timeout0: transfers=%0d want %0d", k, TOT0);
    end
    checks++;
    if (v0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b1 ||
        vc0 !== 16'(TOT0) || a0 !== ea || b0 !== eb) begin
      errors++;
      $display("FAIL end0: v=%b busy=%b done=%b vc=%0d a=%h b=%h want 0 0 1 %0d %h %h",
               v0, busy0, done0, vc0, a0, b0, TOT0, ea, eb);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (v0 !== 0 || a0 !== 0 || b0 !== 0 || busy0 !== 0 ||
        done0 !== 0 || vc0 !== 0 || v1 !== 0 || a1 !== 0 ||
        v2 !== 0 || a2 !== 0 || b2 !== 0 || done2 !== 0) begin
      errors++;
      $display("FAIL reset: v0=%b a0=%h b0=%h busy0=%b done0=%b vc0=%0d want all 0",
               v0, a0, b0, busy0, done0, vc0);
    end
    rst0 = 0; rst1 = 0; rst2 = 0;
    rdy0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rdy0 = 1'b0;
    checks++;
    if (v0 !== 0 || vc0 !== 0 || busy0 !== 0) begin
      errors++;
      $display("FAIL idle_ready: v=%b vc=%0d busy=%b want 0 0 0",
               v0, vc0, busy0);
    end
  endtask

  task automatic test_done_hold;
    logic [31:0] ea, eb;
    exp_vec(32, SEED0, TOT0 - 1, ea, eb);
    rdy0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rdy0 = 1'b0;
    checks++;
    if (done0 !== 1'b1 || v0 !== 1'b0 || a0 !== ea ||
        b0 !== eb || vc0 !== 16'(TOT0)) begin
      errors++;
      $display("FAIL done_hold: done=%b v=%b a=%h b=%h vc=%0d want 1 0 %h %h %0d",
               done0, v0, a0, b0, vc0, ea, eb, TOT0);
    end
  endtask

  task automatic test_rst_mid;
    run0(1'b1, 1'b0, 8);
    checks++;
    if (v0 !== 0 || a0 !== 0 || b0 !== 0 || busy0 !== 0 ||
        done0 !== 0 || vc0 !== 0) begin
      errors++;
      $display("FAIL rst_mid: v=%b a=%h b=%h busy=%b done=%b vc=%0d want all 0",
               v0, a0, b0, busy0, done0, vc0);
    end
    @(posedge clk); #1;
    checks++;
    if (v0 !== 0 || busy0 !== 0 || done0 !== 0) begin
      errors++;
      $display("FAIL rst_idle: v=%b busy=%b done=%b want 0 0 0",
               v0, busy0, done0);
    end
    run0(1'b0, 1'b0, -1);
  endtask

  task automatic test_seed1;
    logic [31:0] ea, eb;
    for (int r = 0; r < 2; r++) begin
      start1 = 1'b1;
      rdy1   = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
        exp_vec(32, 32'h1, k, ea, eb);
        checks++;
        if (v1 !== 1'b1 || a1 !== ea || b1 !== eb ||
            vc1 !== 16'(k)) begin
          errors++;
          $display("FAIL vec1[%0d] run%0d: v=%b a=%h b=%h vc=%0d want 1 %h %h %0d",
                   k, r, v1, a1, b1, vc1, ea, eb, k);
        end
        if (k == 6) begin
          checks++;
          if (a1 !== 32'h80200003 || b1 !== 32'hC0300002) begin
            errors++;
            $display("FAIL rnd0: a=%h b=%h want 80200003 c0300002",
                     a1, b1);
          end
        end
        if (k == 7) begin
          checks++;
          if (a1 !== 32'h60180001 || b1 !== 32'hB02C0003) begin
            errors++;
            $display("FAIL rnd1: a=%h b=%h want 60180001 b02c0003",
                     a1, b1);
          end
        end
        @(posedge clk); #1;
      end
      checks++;
      if (v1 !== 0 || busy1 !== 0 || done1 !== 1 ||
          vc1 !== 16'd10 || a1 !== ea || b1 !== eb) begin
        errors++;
        $display("FAIL end1 run%0d: v=%b busy=%b done=%b vc=%0d a=%h want 0 0 1 10 %h",
                 r, v1, busy1, done1, vc1, a1, ea);
      end
    end
    rdy1 = 1'b0;
  endtask

  task automatic test_narrow;
    logic [31:0] ea, eb;
    start2 = 1'b1;
    rdy2   = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    ea = 0; eb = 0;
    for (int k = 0; k < 6; k++) begin
      exp_vec(8, SEED0, k, ea, eb);
      checks++;
      if (v2 !== 1'b1 || a2 !== ea[7:0] || b2 !== eb[7:0]) begin
        errors++;
        $display("FAIL vec2[%0d]: v=%b a=%h b=%h want 1 %h %h",
                 k, v2, a2, b2, ea[7:0], eb[7:0]);
      end
      if (k == 3) begin
        checks++;
        if (a2 !== 8'h80 || b2 !== 8'hFF) begin
          errors++;
          $display("FAIL min8: a=%h b=%h want 80 ff", a2, b2);
        end
      end
      @(posedge clk); #1;
    end
    rdy2 = 1'b0;
    checks++;
    if (v2 !== 0 || busy2 !== 0 || done2 !== 1 ||
        vc2 !== 16'd6 || a2 !== 8'hF9 || b2 !== 8'h02) begin
      errors++;
      $display("FAIL end2: v=%b busy=%b done=%b vc=%0d a=%h b=%h want 0 0 1 6 f9 02",
               v2, busy2, done2, vc2, a2, b2);
    end
  endtask

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    start0 = 0; start1 = 0; start2 = 0;
    rdy0 = 0; rdy1 = 0; rdy2 = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    run0(1'b0, 1'b0, -1);
    test_done_hold();
    run0(1'b1, 1'b0, -1);
    run0(1'b1, 1'b1, -1);
    test_rst_mid();
    test_seed1();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_stim_gen.md
# div_stim_gen

Synthesizable operand sequencer that sits directly upstream of the signed divider (`DIV`) and drives its `a`/`b` inputs. It emits a fixed set of directed corner vectors, including divide-by-zero and overflow, then a repeatable pseudo-random stream from a 32-bit Galois LFSR. Output is over a valid/ready handshake, so the divider bench, the reference model and the error monitor all consume identical operand pairs.

## Interface
- DATAWIDTH, 32, operand width; legal range 2..32
- NUM_RANDOM, 1024, number of random vectors emitted after the directed set; NUM_RANDOM+6 ≤ 65535
- SEED, 32'hACE12468, LFSR load value; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- out_ready  in  1  consumer accepts the current vector
- out_valid  out  1  a/b hold a valid vector
- a  out  DATAWIDTH  signed dividend
- b  out  DATAWIDTH  signed divisor
- busy  out  1  high in DIRECTED and RANDOM
- done  out  1  high in DONE
- vec_count  out  16  number of vectors transferred in the current run

## Operation
- States: IDLE, DIRECTED, RANDOM, DONE.
- IDLE/DONE with start=1: go to DIRECTED, set index 0, clear vec_count, clear done, and load LFSR with SEED. Runs are therefore repeatable.
- start is ignored while busy.
- Transfer means out_valid & out_ready at a rising clk edge. Each transfer increments vec_count.
- Directed vectors (a, b) by index:
  - 0: (0, 0)
  - 1: (1, 0)
  - 2: (−1, 0)
  - 3: (MIN, −1), where MIN = 1 followed by DATAWIDTH−1 zeros
  - 4: (7, −2)
  - 5: (−7, 2)
- Transfer of index 5 → RANDOM.
- LFSR step: next = (s >> 1) ^ (s[0] ? 32'h80200003 : 0).
- With L(0)=SEED and L(n+1)=step(L(n)), random vector k (k = 0..NUM_RANDOM−1) is:
  - a = L(2k+1)[DATAWIDTH−1:0]
  - b = L(2k+2)[DATAWIDTH−1:0]
  - The LFSR advances exactly two steps per transfer.
- Transfer of random vector NUM_RANDOM−1 → DONE.
- NUM_RANDOM = 0: go from index 5 directly to DONE.
- No arithmetic is performed on operands; the block only produces bit patterns.

## Timing
- Reset values: out_valid=0, a=0, b=0, busy=0, done=0, vec_count=0. State = IDLE, LFSR = SEED.
- start high at edge N (in IDLE): at N+1, out_valid=1, busy=1, vector index 0 is presented.
- out_valid=1 with out_ready=0: a, b and out_valid hold stable indefinitely; the LFSR and vec_count do not change.
- Transfer at edge M: the next vector appears at M (registered update). out_valid stays 1, so there are no bubbles. Continuous out_ready gives one vector per cycle.
- Transfer of the final vector at edge M: at M, out_valid=0, busy=0, done=1, vec_count=NUM_RANDOM+6.
  - a and b hold the last vector.
  - done stays high until the next start or rst.
- start in DONE at edge N behaves as from IDLE; done falls at N+1.
- rst mid-run has priority over everything, including a transfer in the same cycle. All outputs take reset values at the next edge.
- out_ready while out_valid=0 has no effect.

## Test plan
- Reset, then start, with out_ready tied 1 and DATAWIDTH=32 → the first 6 vectors are (0,0), (1,0), (−1,0), (32'h80000000,−1), (7,−2), (−7,2) on consecutive cycles.
- SEED=1 with out_ready=1 → random vector 0 = (32'h80200003, 32'hC0300002) and vector 1 = (32'h60180001, 32'hB02C0003).
- out_ready toggled pseudo-randomly → a/b stay stable while stalled, the sequence matches the out_ready=1 run exactly, and there are no duplicates or skips.
- NUM_RANDOM=4 → done rises on the edge of the 10th transfer, vec_count=10, out_valid=0; start asserted again replays an identical sequence.
- rst asserted at random vector 2 → next cycle all outputs are 0 and the state is IDLE; a subsequent start replays from (0,0).
- start pulsed during RANDOM → no effect on state, the LFSR or vec_count.
